ceff_tx: RTL

Transmit-side counterpart of the capture-enable register: accepts a wide word on a ready/valid handshake and emits it as a paced sequence of SIZE-bit single-cycle valid/data strobes, LSB beat first. The strobe output has no backpressure and drives the valid/data inputs of one or more capture-enable registers downstream, one beat per strobe. It sits between a wide producer (register file, DMA staging) and narrow capture/sampling logic.

---
 rtl/ceff_tx.sv | 86 ++++++++
 1 files changed

// File: rtl/ceff_tx.sv
// ceff_tx: serialises a SIZE*BEATS word into paced SIZE-bit valid/data strobes, LSB beat first.
// Ports: clk, reset (sync active-high); valid_i/ready_o/data_i word handshake;
// valid_o/data_o/last_o beat strobe (no backpressure); busy_o word in flight.
// Option CEFF_TX_PARITY_EN adds parity_o = even parity (XOR) of data_o.
module ceff_tx #(
  parameter int SIZE  = 8,
  parameter int BEATS = 4,
  parameter int GAP   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [SIZE*BEATS-1:0] data_i,
  output logic                  valid_o,
  output logic [SIZE-1:0]       data_o,
  output logic                  last_o,
  output logic                  busy_o
`ifdef CEFF_TX_PARITY_EN
  ,output logic                 parity_o
`endif
);
  localparam int W  = SIZE * BEATS;
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int GW = GAP > 0 ? $clog2(GAP + 1) : 1;
  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
  state_t state_q, state_d;
  logic [W-1:0] shift_q, shift_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [SIZE-1:0] data_q, data_d;
  logic rdy_q;
  logic beat_last;
  assign beat_last = beat_q == BW'(BEATS - 1);
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    unique case (state_q)
      IDLE: if (valid_i && rdy_q) begin
        shift_d = data_i;
        beat_d  = '0;
        state_d = SEND;
      end
      SEND: begin
        shift_d = shift_q >> SIZE;
        beat_d  = beat_q + 1'b1;
        state_d = beat_last ? IDLE : (GAP == 0 ? SEND : WAIT);
        gap_d   = GW'(GAP > 0 ? GAP - 1 : 0);
      end
      WAIT: begin
        state_d = gap_q == '0 ? SEND : WAIT;
        gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // data_o only moves when a beat is about to be presented, so it holds through gaps
    data_d = state_d == SEND ? shift_d[SIZE-1:0] : data_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      beat_q  <= '0;
      gap_q   <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      rdy_q   <= state_d == IDLE;
    end
  end
  assign ready_o = rdy_q;
  assign valid_o = state_q == SEND;
  assign last_o  = valid_o && beat_last;
  assign busy_o  = state_q != IDLE;
  assign data_o  = data_q;
`ifdef CEFF_TX_PARITY_EN
  assign parity_o = ^data_q;
`endif
endmodule
